// File: rtl/ps2_letter_tx.sv
// Device-side PS/2 transmitter: sends the set-2 make code for a letter A..Z as 11-bit frames.
// Define PS2_TX_BREAK_EN to send make, F0, make (press then release) for each accepted letter.
module ps2_letter_tx #(
    parameter int CLK_HALF = 2500,
    parameter int GAP      = 50000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [4:0] letter,
    input  logic       valid,
    output logic       ready,
    output logic       done,
    output logic       err,
    output logic       ps2_clk_out,
    output logic       ps2_dat_out
);

    localparam int CNT_MAX = (CLK_HALF > GAP) ? CLK_HALF : GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HALF_TC = CW'(CLK_HALF - 1);
    localparam logic [CW-1:0] GAP_TC  = CW'(GAP - 1);
    localparam logic [3:0]    STOP_BIT = 4'd10;
`ifdef PS2_TX_BREAK_EN
    localparam logic [1:0]    LAST_BYTE = 2'd2;
`else
    localparam logic [1:0]    LAST_BYTE = 2'd0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BIT_HI = 2'd1,
        ST_BIT_LO = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    function automatic logic [7:0] make_code(input logic [4:0] idx);
        logic [7:0] code;
        case (idx)
            5'd0:    code = 8'h1C;
            5'd1:    code = 8'h32;
            5'd2:    code = 8'h21;
            5'd3:    code = 8'h23;
            5'd4:    code = 8'h24;
            5'd5:    code = 8'h2B;
            5'd6:    code = 8'h34;
            5'd7:    code = 8'h33;
            5'd8:    code = 8'h43;
            5'd9:    code = 8'h3B;
            5'd10:   code = 8'h42;
            5'd11:   code = 8'h4B;
            5'd12:   code = 8'h3A;
            5'd13:   code = 8'h31;
            5'd14:   code = 8'h44;
            5'd15:   code = 8'h4D;
            5'd16:   code = 8'h15;
            5'd17:   code = 8'h2D;
            5'd18:   code = 8'h1B;
            5'd19:   code = 8'h2C;
            5'd20:   code = 8'h3C;
            5'd21:   code = 8'h2A;
            5'd22:   code = 8'h1D;
            5'd23:   code = 8'h22;
            5'd24:   code = 8'h35;
            5'd25:   code = 8'h1A;
            default: code = 8'h00;
        endcase
        return code;
    endfunction

    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

    // Bit 0 is the start bit, 1..8 data LSB first, 9 parity, 10 stop; anything beyond reads as idle-high.
    function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
        logic [15:0] frame;
        frame = {5'b11111, 1'b1, odd_parity(data), data, 1'b0};
        return frame[idx];
    endfunction

    state_t        state_r, state_nx;
    logic [CW-1:0] cnt_r, cnt_nx;
    logic [3:0]    bit_r, bit_nx;
    logic [1:0]    byte_r, byte_nx;
    logic [7:0]    make_r, make_nx;
    logic          clk_r, clk_nx;
    logic          dat_r, dat_nx;
    logic          ready_r, ready_nx;
    logic          done_r, done_nx;
    logic          err_r, err_nx;
    logic          accept_s;
    logic [7:0]    cur_byte_s;

`ifdef PS2_TX_BREAK_EN
    assign cur_byte_s = (byte_r == 2'd1) ? 8'hF0 : make_r;
`else
    assign cur_byte_s = make_r;
`endif

    assign accept_s = valid && ready_r;

    // Next-state, counter and output-register values
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        bit_nx   = bit_r;
        byte_nx  = byte_r;
        make_nx  = make_r;
        dat_nx   = dat_r;
        ready_nx = 1'b0;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                dat_nx  = 1'b1;
                cnt_nx  = {CW{1'b0}};
                bit_nx  = 4'd0;
                byte_nx = 2'd0;
                if (accept_s) begin
                    if (letter > 5'd25) begin
                        err_nx = 1'b1;
                    end else begin
                        state_nx = ST_BIT_HI;
                        make_nx  = make_code(letter);
                        dat_nx   = 1'b0;
                    end
                end else begin
                    ready_nx = 1'b1;
                end
            end
            ST_BIT_HI: begin
                if (cnt_r == HALF_TC) begin
                    cnt_nx   = {CW{1'b0}};
                    state_nx = ST_BIT_LO;
                end else begin
                    cnt_nx = cnt_r + CW'(1);
                end
            end
            ST_BIT_LO: begin
                if (cnt_r == HALF_TC) begin
                    cnt_nx = {CW{1'b0}};
                    if (bit_r == STOP_BIT) begin
                        state_nx = ST_GAP;
                        dat_nx   = 1'b1;
                    end else begin
                        state_nx = ST_BIT_HI;
                        bit_nx   = bit_r + 4'd1;
                        dat_nx   = frame_bit(cur_byte_s, bit_r + 4'd1);
                    end
                end else begin
                    cnt_nx = cnt_r + CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_TC) begin
                    cnt_nx = {CW{1'b0}};
                    if (byte_r == LAST_BYTE) begin
                        state_nx = ST_IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = ST_BIT_HI;
                        byte_nx  = byte_r + 2'd1;
                        bit_nx   = 4'd0;
                        dat_nx   = 1'b0;
                    end
                end else begin
                    cnt_nx = cnt_r + CW'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = {CW{1'b0}};
                dat_nx   = 1'b1;
            end
        endcase
        clk_nx = (state_nx != ST_BIT_LO);
    end

    // State, counters and registered line/handshake outputs
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            bit_r   <= 4'd0;
            byte_r  <= 2'd0;
            make_r  <= 8'h00;
            clk_r   <= 1'b1;
            dat_r   <= 1'b1;
            ready_r <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            bit_r   <= bit_nx;
            byte_r  <= byte_nx;
            make_r  <= make_nx;
            clk_r   <= clk_nx;
            dat_r   <= dat_nx;
            ready_r <= ready_nx;
            done_r  <= done_nx;
            err_r   <= err_nx;
        end
    end

    assign ready       = ready_r;
    assign done        = done_r;
    assign err         = err_r;
    assign ps2_clk_out = clk_r;
    assign ps2_dat_out = dat_r;

endmodule

// File: tb/tb_ps2_letter_tx.sv
// Self-checking bench for ps2_letter_tx: a cycle-level waveform model derived from frame arithmetic,
// plus literal frame/latency expectations for specific letters.
module tb_ps2_letter_tx;

    localparam int CH = 4;
    localparam int G  = 10;
    localparam int P  = 22 * CH + G;
`ifdef PS2_TX_BREAK_EN
    localparam int NB = 3;
    localparam int LAT_LIT  = 295;
    localparam int PAIR_LIT = 296;
`else
    localparam int NB = 1;
    localparam int LAT_LIT  = 99;
    localparam int PAIR_LIT = 100;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic [4:0] letter;
    logic       valid;
    logic       ready;
    logic       done;
    logic       err;
    logic       ps2_clk_out;
    logic       ps2_dat_out;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [7:0] mk_tab [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

    ps2_letter_tx #(.CLK_HALF(CH), .GAP(G)) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .letter     (letter),
        .valid      (valid),
        .ready      (ready),
        .done       (done),
        .err        (err),
        .ps2_clk_out(ps2_clk_out),
        .ps2_dat_out(ps2_dat_out)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial forever begin
        @(posedge CLOCK_50);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bits seen on each falling edge of the PS/2 clock
    logic q [$];
    logic prev_clk = 1'b1;
    initial forever begin
        @(negedge CLOCK_50);
        if (prev_clk === 1'b1 && ps2_clk_out === 1'b0) q.push_back(ps2_dat_out);
        prev_clk = ps2_clk_out;
    end

    function automatic logic [10:0] frame_at(input int base);
        logic [10:0] f;
        f = 11'b0;
        for (int i = 0; i < 11; i++) begin
            if (base + i < q.size()) f = {q[base + i], f[10:1]};
            else                     f = {1'bx, f[10:1]};
        end
        return f;
    endfunction

    // Behavioural model: expected lines computed from the offset since acceptance
    typedef enum int {M_RST, M_IDLE, M_ERR, M_TX} mmode_t;
    mmode_t     m_mode = M_RST;
    int         m_k    = 0;
    logic [7:0] m_codes [3];

    task automatic tx_expect(input int k, output logic e_clk, output logic e_dat, output logic e_done);
        logic [10:0] fr;
        logic [7:0]  code;
        int j, b, pos, bi;
        e_clk  = 1'b1;
        e_dat  = 1'b1;
        e_done = 1'b0;
        if (k <= NB * P) begin
            j   = k - 1;
            b   = j / P;
            pos = j % P;
            if (pos < 22 * CH) begin
                code  = m_codes[b[1:0]];
                fr    = {1'b1, ~(^code), code, 1'b0};
                bi    = pos / (2 * CH);
                e_clk = ((pos % (2 * CH)) < CH);
                e_dat = fr[bi[3:0]];
            end
        end else begin
            e_done = (k == NB * P + 1);
        end
    endtask

    initial forever begin
        logic e_clk, e_dat, e_done, e_err, e_rdy;
        logic [7:0] mk;
        @(negedge CLOCK_50);
        if (resetn !== 1'b1) m_mode = M_RST;
        e_clk = 1'b1; e_dat = 1'b1; e_done = 1'b0; e_err = 1'b0; e_rdy = 1'b0;
        case (m_mode)
            M_IDLE:  e_rdy = 1'b1;
            M_ERR:   e_err = 1'b1;
            M_TX:    tx_expect(m_k, e_clk, e_dat, e_done);
            default: e_rdy = 1'b0;
        endcase
        chk("cycle{rdy,done,err,clk,dat}",
            {27'd0, ready, done, err, ps2_clk_out, ps2_dat_out},
            {27'd0, e_rdy, e_done, e_err, e_clk, e_dat});
        case (m_mode)
            M_RST:  if (resetn === 1'b1) m_mode = M_IDLE;
            M_IDLE: if (valid === 1'b1) begin
                if (letter > 5'd25) begin
                    m_mode = M_ERR;
                end else begin
                    mk = mk_tab[letter];
                    m_codes[0] = mk;
                    m_codes[1] = 8'hF0;
                    m_codes[2] = mk;
                    m_mode = M_TX;
                    m_k = 1;
                end
            end
            M_ERR:  m_mode = M_IDLE;
            M_TX:   if (m_k == NB * P + 1) m_mode = M_IDLE; else m_k = m_k + 1;
            default: m_mode = M_RST;
        endcase
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send(input logic [4:0] l, output int t_acc);
        valid  = 1'b1;
        letter = l;
        t_acc  = cyc;
        tick();
        valid  = 1'b0;
    endtask

    task automatic wait_done(input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < NB * P + 50; i++) begin
            @(negedge CLOCK_50);
            #1;
            if (done === 1'b1) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    initial begin
        int t0, t1, t2, lat;
        bit seen;
        resetn = 1'b0;
        valid  = 1'b0;
        letter = 5'd0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("reset_lines", 32'({ps2_clk_out, ps2_dat_out, ready, done, err}), 32'b11000);
        resetn = 1'b1;
        tick();
        chk("ready_after_reset", 32'(ready), 32'd1);

        // Z -> 1A
        q.delete();
        send(5'd25, t0);
        wait_done(t0, lat);
        chk("lat_Z", 32'(lat), 32'(LAT_LIT));
        chk("frame_Z", 32'(frame_at(0)), 32'(11'b10000110100));
        chk("bits_Z", 32'(q.size()), 32'(11 * NB));
        tick();

        // Q -> 15, letter changed after acceptance
        q.delete();
        send(5'd16, t0);
        letter = 5'd3;
        wait_done(t0, lat);
        chk("lat_Q", 32'(lat), 32'(LAT_LIT));
        chk("frame_Q", 32'(frame_at(0)), 32'(11'b10000101010));
        tick();

        // Out-of-range letter
        q.delete();
        send(5'd26, t0);
        @(negedge CLOCK_50);
        chk("err_pulse", 32'({err, ready, ps2_clk_out, ps2_dat_out}), 32'b1011);
        tick();
        @(negedge CLOCK_50);
        chk("ready_after_err", 32'({ready, err, done}), 32'b100);
        repeat (20) tick();
        chk("no_bits_err", 32'(q.size()), 32'd0);

        // A -> 1C (and F0, 1C with break codes)
        q.delete();
        send(5'd0, t0);
        wait_done(t0, lat);
        chk("lat_A", 32'(lat), 32'(LAT_LIT));
        chk("frame_A", 32'(frame_at(0)), 32'(11'b10000111000));
`ifdef PS2_TX_BREAK_EN
        chk("frame_F0", 32'(frame_at(11)), 32'(11'b11111000000));
        chk("frame_A_rel", 32'(frame_at(22)), 32'(11'b10000111000));
`endif
        tick();

        // Reset during the low half of data bit 3
        q.delete();
        send(5'd7, t0);
        for (int i = 0; i < 200 && q.size() < 5; i++) begin
            @(negedge CLOCK_50);
            #1;
        end
        chk("reached_bit3", 32'(q.size()), 32'd5);
        tick();
        chk("bit3_low", 32'(ps2_clk_out), 32'd0);
        resetn = 1'b0;
        #1;
        chk("reset_mid_lines", 32'({ps2_clk_out, ps2_dat_out, ready}), 32'b110);
        repeat (2) tick();
        resetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLOCK_50);
            if (done === 1'b1 || ps2_clk_out !== 1'b1) seen = 1'b1;
        end
        chk("no_resume_after_reset", 32'(seen), 32'd0);
        tick();
        q.delete();
        send(5'd4, t0);
        wait_done(t0, lat);
        chk("lat_E_after_reset", 32'(lat), 32'(LAT_LIT));
        chk("frame_E_after_reset", 32'(frame_at(0)), 32'(11'b11001001000));
        tick();

        // valid held high across two letters
        q.delete();
        valid  = 1'b1;
        letter = 5'd4;
        t1 = cyc;
        tick();
        letter = 5'd5;
        wait_done(t1, lat);
        chk("lat_hold_E", 32'(lat), 32'(LAT_LIT));
        tick();
        t2 = cyc;
        tick();
        valid = 1'b0;
        chk("second_accept_gap", 32'(t2 - t1), 32'(PAIR_LIT));
        wait_done(t2, lat);
        chk("lat_hold_F", 32'(lat), 32'(LAT_LIT));
        chk("frame_hold_E", 32'(frame_at(0)), 32'(11'b11001001000));
        chk("frame_hold_F", 32'(frame_at(11 * NB)), 32'(11'b11001010110));
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_letter_tx.md
PS2_LETTER_TX -- requirements
Module: ps2_letter_tx

Interface
REQ-001 Parameter CLK_HALF, default 2500, CLOCK_50 cycles per PS/2 clock half-period (10 kHz PS/2 clock).
REQ-002 Parameter GAP, default 50000, CLOCK_50 cycles of idle line between consecutive bytes (1 ms).
REQ-003 CLOCK_50  input  1  system clock; the only clock; all state updates on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 letter  input  5  letter index, 0 = A through 25 = Z.
REQ-006 valid  input  1  request to transmit letter.
REQ-007 ready  output  1  high when a request can be accepted.
REQ-008 done  output  1  one-cycle pulse when a letter's full byte sequence has finished.
REQ-009 err  output  1  one-cycle pulse when an out-of-range letter is rejected.
REQ-010 ps2_clk_out  output  1  device-side PS/2 clock; idle high.
REQ-011 ps2_dat_out  output  1  device-side PS/2 data; idle high.

Function
REQ-012 Acceptance occurs on a cycle with valid=1 and ready=1; letter is captured on that cycle; ready=0 from the next cycle until return to IDLE.
REQ-013 The block shall map letter to make code: A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31, O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A.
REQ-014 Letter 26-31 on acceptance: err pulses the next cycle, no line activity, no done, ready returns high the cycle after err.
REQ-015 Frame per byte: 11 bits -- start 0, data bits 0..7 LSB first, odd parity, stop 1.
REQ-016 States: IDLE, BIT_HI, BIT_LO, GAP; IDLE->BIT_HI on valid acceptance; BIT_HI->BIT_LO after CLK_HALF cycles; BIT_LO->BIT_HI (next bit) after CLK_HALF cycles, or ->GAP after the stop bit; GAP->BIT_HI (next byte) or ->IDLE after GAP cycles.
REQ-017 ps2_dat_out changes only at entry to BIT_HI while ps2_clk_out is high; ps2_clk_out=0 exactly during BIT_LO, so the receiver samples on the falling edge.
REQ-018 First BIT_HI begins the cycle after acceptance; each bit lasts 2*CLK_HALF cycles; each byte occupies 22*CLK_HALF+GAP cycles.
REQ-019 done pulses on the cycle GAP->IDLE after the last byte; ready is high the following cycle.
REQ-020 valid while ready=0 is ignored and not queued; letter changes after acceptance have no effect.
REQ-021 In IDLE and GAP both lines are high.
REQ-022 Bit and half-period counters are sized to hold CLK_HALF and GAP without overflow; terminal count is value-1, then reloads to 0.

Reset
REQ-023 resetn=0 forces, without waiting for a clock edge: state IDLE, ps2_clk_out=1, ps2_dat_out=1, ready=0, done=0, err=0, all counters 0.
REQ-024 ready shall be 1 from the first rising edge of CLOCK_50 after resetn deasserts.
REQ-025 Reset mid-frame abandons the byte; no done; no partial resumption after release.

Configuration
REQ-026 Macro PS2_TX_BREAK_EN defined: each accepted letter sends three bytes -- make code, F0, make code (press then release).
REQ-027 PS2_TX_BREAK_EN undefined: each accepted letter sends the make code only; done follows that byte's GAP.

Verification
REQ-028 PS2_TX_BREAK_EN, letter=0, valid 1 cycle -> bytes 1C (parity 0), F0 (parity 1), 1C; done once after 3*(22*CLK_HALF+GAP) cycles plus 1 cycle.
REQ-029 letter=25 -> data bits on falling clock edges 0,0,1,0,1,1,0,0,0, parity 0, stop 1 (1A).
REQ-030 letter=26 -> err pulse next cycle, lines stay high, done never asserts, ready high after err.
REQ-031 resetn low during BIT_LO of data bit 3 -> both lines high immediately, no done; new letter accepted after release transmits correctly.
REQ-032 valid held high continuously for letters 4 then 5 -> only one letter per ready window; E (24) completes before the second acceptance.
REQ-033 PS2_TX_BREAK_EN undefined, letter=16 -> single byte 15 (parity 0); done after 22*CLK_HALF+GAP+1 cycles.
